// File: rtl/serial_comparator_if.sv
// serial_comparator_if
//   Host-side bundle for the serial magnitude comparator.
//   master: host (drives start, a, b, is_signed; observes status/results)
//   slave : comparator (observes request; drives busy, done, results)
//   SIZE must match the SIZE parameter of the attached comparator.
interface serial_comparator_if #(
   parameter int SIZE = 8
);
   logic            start;
   logic [SIZE-1:0] a;
   logic [SIZE-1:0] b;
   logic            is_signed;
   logic            busy;
   logic            done;
   logic            is_a_greater;
   logic            is_a_less;
   logic            equal;

   modport master (
      output start, a, b, is_signed,
      input  busy, done, is_a_greater, is_a_less, equal
   );

   modport slave (
      input  start, a, b, is_signed,
      output busy, done, is_a_greater, is_a_less, equal
   );
endinterface

// File: rtl/serial_comparator.sv
// serial_comparator
//   Multi-cycle magnitude comparator: compares two SIZE-bit operands DIGIT
//   bits per cycle, MSB first, unsigned or two's-complement, optionally
//   stopping on the first unequal digit.
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    serial_comparator_if.slave: start/a/b/is_signed in;
//          busy/done/is_a_greater/is_a_less/equal out
module serial_comparator #(
   parameter int SIZE       = 8,
   parameter int DIGIT      = 1,
   parameter int EARLY_EXIT = 0
) (
   input logic                clk,
   input logic                reset,
   serial_comparator_if.slave bus
);
   localparam int N   = (SIZE + DIGIT - 1) / DIGIT;  // steps per operation
   localparam int PW  = N * DIGIT;                   // padded operand width
   localparam int PAD = PW - SIZE;                   // zero bits added at LSB end
   localparam int CW  = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   op_a;
   logic [PW-1:0]   op_b;
   logic [CW-1:0]   step;
   logic            gt;
   logic            lt;
   logic [DIGIT-1:0] dig_a;
   logic [DIGIT-1:0] dig_b;
   logic            decided;
   logic            gt_next;
   logic            lt_next;
   logic            last_step;
   logic [SIZE-1:0] sign_flip;
   logic            res_gt;
   logic            res_lt;
   logic            res_eq;

   // Operands are shifted left each step, so the current digit is always
   // the top DIGIT bits.
   assign dig_a     = op_a[PW-1 -: DIGIT];
   assign dig_b     = op_b[PW-1 -: DIGIT];
   assign decided   = gt | lt;
   // Once a digit has decided, later digits are masked off.
   assign gt_next   = gt | (!decided && (dig_a > dig_b));
   assign lt_next   = lt | (!decided && (dig_a < dig_b));
   assign last_step = (step == CW'(N - 1));
   // Inverting both MSBs maps two's-complement order onto unsigned order.
   assign sign_flip = SIZE'(bus.is_signed) << (SIZE - 1);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: every signal written here gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.start) state_next = RUN;
         RUN: begin
            if (last_step || ((EARLY_EXIT != 0) && (gt_next || lt_next)))
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the reset clears operands and results too, so an aborted run
   // leaves nothing stale on the outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_a   <= '0;
         op_b   <= '0;
         step   <= '0;
         gt     <= 1'b0;
         lt     <= 1'b0;
         res_gt <= 1'b0;
         res_lt <= 1'b0;
         res_eq <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_a <= PW'(bus.a ^ sign_flip) << PAD;
                  op_b <= PW'(bus.b ^ sign_flip) << PAD;
                  step <= '0;
                  gt   <= 1'b0;
                  lt   <= 1'b0;
               end
            end
            RUN: begin
               op_a <= op_a << DIGIT;
               op_b <= op_b << DIGIT;
               step <= step + 1'b1;
               gt   <= gt_next;
               lt   <= lt_next;
               if (state_next == DONE) begin
                  res_gt <= gt_next;
                  res_lt <= lt_next;
                  res_eq <= !(gt_next || lt_next);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy         = (state != IDLE);
   assign bus.done         = (state == DONE);
   assign bus.is_a_greater = res_gt;
   assign bus.is_a_less    = res_lt;
   assign bus.equal        = res_eq;
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator
//   Directed bench for serial_comparator. Three instances share clk/reset:
//     sel 0: SIZE=8  DIGIT=1 EARLY_EXIT=0
//     sel 1: SIZE=8  DIGIT=1 EARLY_EXIT=1
//     sel 2: SIZE=10 DIGIT=4 EARLY_EXIT=0 (LSB padding)
//   Latency "cyc" counts cycles from the start cycle to the done cycle.
module tb_serial_comparator;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   serial_comparator_if #(.SIZE(8))  if0 ();
   serial_comparator_if #(.SIZE(8))  if1 ();
   serial_comparator_if #(.SIZE(10)) if2 ();

   serial_comparator #(.SIZE(8), .DIGIT(1), .EARLY_EXIT(0)) dut0 (
      .clk(clk), .reset(reset), .bus(if0));
   serial_comparator #(.SIZE(8), .DIGIT(1), .EARLY_EXIT(1)) dut1 (
      .clk(clk), .reset(reset), .bus(if1));
   serial_comparator #(.SIZE(10), .DIGIT(4), .EARLY_EXIT(0)) dut2 (
      .clk(clk), .reset(reset), .bus(if2));

   localparam logic [2:0] GT = 3'b100;
   localparam logic [2:0] LT = 3'b010;
   localparam logic [2:0] EQ = 3'b001;

   typedef struct {
      int         sel;
      logic [9:0] a;
      logic [9:0] b;
      logic       s;
      logic [2:0] res;
      int         cyc;
   } vec_t;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [9:0] a,
                        input logic [9:0] b, input logic s);
      case (sel)
         0: begin if0.start = st; if0.a = a[7:0]; if0.b = b[7:0]; if0.is_signed = s; end
         1: begin if1.start = st; if1.a = a[7:0]; if1.b = b[7:0]; if1.is_signed = s; end
         default: begin if2.start = st; if2.a = a; if2.b = b; if2.is_signed = s; end
      endcase
   endtask

   // {busy, done, is_a_greater, is_a_less, equal}
   function automatic logic [4:0] get(input int sel);
      case (sel)
         0: return {if0.busy, if0.done, if0.is_a_greater, if0.is_a_less, if0.equal};
         1: return {if1.busy, if1.done, if1.is_a_greater, if1.is_a_less, if1.equal};
         default: return {if2.busy, if2.done, if2.is_a_greater, if2.is_a_less, if2.equal};
      endcase
   endfunction

   task automatic run_op(input string name, input int sel, input logic [9:0] a,
                         input logic [9:0] b, input logic s,
                         output logic [2:0] res, output int cyc);
      logic [4:0] st;
      @(negedge clk);
      drive(sel, 1'b1, a, b, s);
      @(posedge clk);
      #1;
      // Scramble inputs after accept: results must follow the captured values.
      drive(sel, 1'b0, ~a, ~b, ~s);
      st = get(sel);
      check({name, "_busy"}, 32'(st[4]), 32'd1);
      cyc = 1;
      while (!st[3] && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         st = get(sel);
      end
      res = st[2:0];
      @(posedge clk);
      #1;
      st = get(sel);
      check({name, "_done_width"}, 32'(st[4:3]), 32'd0);
   endtask

   vec_t       vecs[19];
   logic [2:0] res;
   int         cyc;
   logic [4:0] st;
   logic       late_done;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{0, 10'h080, 10'h07F, 1'b0, GT, 9};
      vecs[1]  = '{0, 10'h080, 10'h07F, 1'b1, LT, 9};
      vecs[2]  = '{0, 10'h000, 10'h000, 1'b0, EQ, 9};
      vecs[3]  = '{0, 10'h0FF, 10'h000, 1'b1, LT, 9};
      vecs[4]  = '{0, 10'h0FF, 10'h0FE, 1'b1, GT, 9};
      vecs[5]  = '{0, 10'h07F, 10'h080, 1'b1, GT, 9};
      vecs[6]  = '{0, 10'h001, 10'h002, 1'b0, LT, 9};
      vecs[7]  = '{0, 10'h0A5, 10'h0A5, 1'b1, EQ, 9};
      vecs[8]  = '{0, 10'h0FE, 10'h0FF, 1'b0, LT, 9};
      vecs[9]  = '{1, 10'h05A, 10'h05A, 1'b0, EQ, 9};
      vecs[10] = '{1, 10'h080, 10'h000, 1'b0, GT, 2};
      vecs[11] = '{1, 10'h001, 10'h000, 1'b0, GT, 9};
      vecs[12] = '{1, 10'h040, 10'h000, 1'b0, GT, 3};
      vecs[13] = '{1, 10'h080, 10'h000, 1'b1, LT, 2};
      vecs[14] = '{1, 10'h010, 10'h018, 1'b0, LT, 6};
      vecs[15] = '{2, 10'h3FF, 10'h3FE, 1'b0, GT, 4};
      vecs[16] = '{2, 10'h200, 10'h1FF, 1'b1, LT, 4};
      vecs[17] = '{2, 10'h000, 10'h000, 1'b0, EQ, 4};
      vecs[18] = '{2, 10'h1FF, 10'h200, 1'b0, LT, 4};

      reset = 1'b1;
      for (int s = 0; s < 3; s++) drive(s, 1'b0, 10'h0, 10'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) check($sformatf("reset_state%0d", s), 32'(get(s)), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven operations
      for (int i = 0; i < 19; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].s, res, cyc);
         check($sformatf("vec%0d_res", i), 32'(res), 32'(vecs[i].res));
         check($sformatf("vec%0d_cyc", i), 32'(cyc), 32'(vecs[i].cyc));
      end

      // start held high with operands changing every cycle: accepts happen
      // before edges 0, 10 and 20 (a = i*13, b = 100); done after edges 8, 18, 28.
      for (int i = 0; i < 30; i++) begin
         logic [7:0] av;
         av = 8'(i * 13);
         @(negedge clk);
         drive(0, 1'b1, {2'b00, av}, 10'd100, 1'b0);
         @(posedge clk);
         #1;
         st = get(0);
         check($sformatf("burst%0d_done", i), 32'(st[3]), 32'((i == 8) || (i == 18) || (i == 28)));
         if (i == 8)  check("burst_res0",  32'(st[2:0]), 32'(LT));
         if (i == 18) check("burst_res10", 32'(st[2:0]), 32'(GT));
         if (i == 28) check("burst_res20", 32'(st[2:0]), 32'(LT));
      end
      @(negedge clk);
      drive(0, 1'b0, 10'h0, 10'h0, 1'b0);
      @(posedge clk);
      #1;
      check("burst_idle", 32'(get(0)), 32'(LT));

      // Reset during step 3 aborts the run
      @(negedge clk);
      drive(0, 1'b1, 10'h033, 10'h044, 1'b0);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 10'h0, 10'h0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_state", 32'(get(0)), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      late_done = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (get(0) != 5'd0) late_done = 1'b1;
      end
      check("abort_quiet", 32'(late_done), 32'd0);
      run_op("after_abort", 0, 10'h033, 10'h044, 1'b0, res, cyc);
      check("after_abort_res", 32'(res), 32'(LT));
      check("after_abort_cyc", 32'(cyc), 32'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
